// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: programming and sequencing controller for the UART baud
// clock generator. It holds the DLL/DLM shadow divisor, applies new divisors
// glitch-free (generator held in reset while the divisor is swapped), and
// derives per-bclk sample ticks and per-bit baud ticks.
// Optional feature macro: UART_BAUD_CTRL_IRQ_EN adds irq_out and the STATUS
// "done" bit (bit4), set whenever a commit-triggered reload finishes.
module uart_baud_ctrl #(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned RST_HOLD = 2,
  parameter int unsigned OVS      = 16
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata,
  input  logic             bclk_in,
  output logic             gen_rstn_out,
  output logic [DIV_W-1:0] divisor_out,
  output logic             busy_out,
  output logic             sample_tick_out,
`ifdef UART_BAUD_CTRL_IRQ_EN
  output logic             irq_out,
`endif
  output logic             baud_tick_out
);

  localparam int unsigned CW = $clog2(OVS);
  localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic             en_q, en_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CW-1:0]    tick_q, tick_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             bsync1_q, bsync2_q, bprev_q;

  logic wr_dll, wr_dlm, wr_ctrl, rd_status;
  logic ctrl_en, ctrl_commit, shadow_ok, bclk_rise, done_bit;
  logic [7:0] status_w;
  logic unused_wdata;

`ifdef UART_BAUD_CTRL_IRQ_EN
  logic done_q, done_d;
  logic via_commit_q, via_commit_d;
  assign done_bit = done_q;
  assign irq_out  = done_q;
`else
  assign done_bit = 1'b0;
`endif

  assign wr_dll      = reg_wr && (reg_addr == 2'd0);
  assign wr_dlm      = reg_wr && (reg_addr == 2'd1);
  assign wr_ctrl     = reg_wr && (reg_addr == 2'd2);
  assign rd_status   = reg_rd && (reg_addr == 2'd3);
  assign ctrl_en     = reg_wdata[0];
  assign ctrl_commit = reg_wdata[1];
  assign shadow_ok   = (shadow_q >= 16'd2);
  assign bclk_rise   = bsync2_q & ~bprev_q;
  assign unused_wdata = ^reg_wdata[7:2];

  assign gen_rstn_out    = (state_q == ST_RUN);
  assign divisor_out     = divisor_q;
  assign busy_out        = (state_q == ST_LOAD) | pending_q;
  assign sample_tick_out = bclk_rise & (state_q == ST_RUN);
  assign baud_tick_out   = sample_tick_out & (tick_q == CW'(OVS - 1));
  assign reg_rdata       = rdata_q;
  assign status_w        = {3'b000, done_bit, err_q, pending_q, en_q, busy_out};

  // Bring the asynchronous bclk into the clock domain and keep the previous
  // synchronised level so a rising edge shows up as a one-cycle strobe.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      bsync1_q <= 1'b0;
      bsync2_q <= 1'b0;
      bprev_q  <= 1'b0;
    end else begin
      bsync1_q <= bclk_in;
      bsync2_q <= bsync1_q;
      bprev_q  <= bsync2_q;
    end
  end

  // Next-state logic: register bus decode, divisor apply sequencing, tick
  // counting; CTRL writes come last so a disable overrides everything else.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    divisor_d = divisor_q;
    en_d      = en_q;
    pending_d = pending_q;
    err_d     = err_q;
    hold_d    = hold_q;
    tick_d    = tick_q;
    rdata_d   = rdata_q;
`ifdef UART_BAUD_CTRL_IRQ_EN
    done_d       = done_q;
    via_commit_d = via_commit_q;
    if (rd_status) done_d = 1'b0;
`endif

    if (wr_dll) shadow_d[7:0]  = reg_wdata;
    if (wr_dlm) shadow_d[15:8] = reg_wdata;
    if (rd_status) err_d = 1'b0;
    if (sample_tick_out) tick_d = tick_q + 1'b1;

    if (reg_rd) begin
      case (reg_addr)
        2'd0:    rdata_d = shadow_q[7:0];
        2'd1:    rdata_d = shadow_q[15:8];
        2'd2:    rdata_d = {7'b0, en_q};
        default: rdata_d = status_w;
      endcase
    end

    case (state_q)
      ST_OFF: begin
        hold_d = '0;
      end
      ST_LOAD: begin
        tick_d = '0;
        if (hold_q == HW'(RST_HOLD - 1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
`ifdef UART_BAUD_CTRL_IRQ_EN
          if (via_commit_q) done_d = 1'b1;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (bclk_rise && pending_q) begin
          state_d   = ST_LOAD;
          divisor_d = DIV_W'(shadow_q);
          pending_d = 1'b0;
          hold_d    = '0;
`ifdef UART_BAUD_CTRL_IRQ_EN
          via_commit_d = 1'b1;
`endif
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (wr_ctrl) begin
      en_d = ctrl_en;
      if (!ctrl_en) begin
        state_d   = ST_OFF;
        pending_d = 1'b0;
      end else if (state_q == ST_OFF) begin
        if (shadow_ok) begin
          state_d   = ST_LOAD;
          divisor_d = DIV_W'(shadow_q);
          hold_d    = '0;
`ifdef UART_BAUD_CTRL_IRQ_EN
          via_commit_d = 1'b0;
`endif
        end else begin
          err_d = 1'b1;
        end
      end else if (ctrl_commit) begin
        if (shadow_ok) pending_d = 1'b1;
        else           err_d     = 1'b1;
      end
    end
  end

  // State and register file update.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q   <= ST_OFF;
      shadow_q  <= '0;
      divisor_q <= '0;
      en_q      <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= '0;
      tick_q    <= '0;
      rdata_q   <= '0;
`ifdef UART_BAUD_CTRL_IRQ_EN
      done_q       <= 1'b0;
      via_commit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      divisor_q <= divisor_d;
      en_q      <= en_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
      tick_q    <= tick_d;
      rdata_q   <= rdata_d;
`ifdef UART_BAUD_CTRL_IRQ_EN
      done_q       <= done_d;
      via_commit_q <= via_commit_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: self-checking bench for uart_baud_ctrl. Drives the
// register bus and a bench-generated bclk, and compares against a counting
// model of the divisor/tick behaviour.
module tb_uart_baud_ctrl;
  localparam int OVS      = 16;
  localparam int RST_HOLD = 2;
`ifdef UART_BAUD_CTRL_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        regWr = 1'b0;
  logic        regRd = 1'b0;
  logic [1:0]  regAddr = 2'd0;
  logic [7:0]  regWdata = 8'd0;
  logic [7:0]  regRdata;
  logic        bclk = 1'b0;
  logic        genRstn;
  logic [15:0] divisor;
  logic        busy;
  logic        sampleTick;
  logic        baudTick;
`ifdef UART_BAUD_CTRL_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  // Observed event counters, accumulated by the monitor below.
  int sampleCount = 0;
  int baudCount = 0;
  int loadCycles = 0;
  int badTicks = 0;

  // Reference model state.
  int mShadow = 0;
  int mDiv = 0;
  bit mEn = 0;
  bit mPend = 0;
  bit mErr = 0;
  bit mDone = 0;
  bit mRun = 0;
  int mSample = 0;
  int mBaud = 0;
  int mSince = 0;
  int mLoads = 0;

  uart_baud_ctrl #(.DIV_W(16), .RST_HOLD(RST_HOLD), .OVS(OVS)) dut (
    .clk_in          (clock),
    .rstn_in         (resetN),
    .reg_wr          (regWr),
    .reg_rd          (regRd),
    .reg_addr        (regAddr),
    .reg_wdata       (regWdata),
    .reg_rdata       (regRdata),
    .bclk_in         (bclk),
    .gen_rstn_out    (genRstn),
    .divisor_out     (divisor),
    .busy_out        (busy),
    .sample_tick_out (sampleTick),
`ifdef UART_BAUD_CTRL_IRQ_EN
    .irq_out         (irq),
`endif
    .baud_tick_out   (baudTick)
  );

  // 100 MHz system clock.
  always #5 clock = ~clock;

  // Count ticks and reload cycles on the falling edge, away from updates.
  always @(negedge clock) begin
    if (sampleTick) sampleCount++;
    if (baudTick) baudCount++;
    if (busy && !genRstn) loadCycles++;
    if (sampleTick && !genRstn) badTicks++;
  end

  // Bound the whole run so a stuck design still ends with a report.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clock);
    regWr = 1'b1; regAddr = addr; regWdata = data;
    @(negedge clock);
    regWr = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [7:0] data);
    @(negedge clock);
    regRd = 1'b1; regAddr = addr;
    @(negedge clock);
    regRd = 1'b0;
    data = regRdata;
  endtask

  function automatic logic [7:0] expStatus();
    return {3'b000, IRQ & mDone, mErr, mPend, mEn, mPend};
  endfunction

  task automatic readStatusCheck(input string tag);
    logic [7:0] d;
    readReg(2'd3, d);
    checkOutput(tag, 32'(d), 32'(expStatus()));
    mErr = 1'b0;
    mDone = 1'b0;
  endtask

  task automatic writeDivisor(input int d);
    applyStimulus(2'd0, 8'(d));
    applyStimulus(2'd1, 8'(d >> 8));
    mShadow = d;
  endtask

  // One bclk period and the model's view of it: a tick while running, the
  // baud tick every OVS ticks since reload, and a pending commit applied.
  task automatic bclkPulse(input int hi, input int lo);
    @(negedge clock);
    bclk = 1'b1;
    repeat (hi) @(negedge clock);
    bclk = 1'b0;
    repeat (lo) @(negedge clock);
    if (mRun) begin
      mSample++;
      mSince++;
      if (mSince % OVS == 0) mBaud++;
      if (mPend) begin
        mPend = 1'b0;
        mDiv = mShadow;
        mSince = 0;
        mLoads += RST_HOLD;
        mDone = 1'b1;
      end
    end
  endtask

  task automatic runPulses(input int k);
    for (int i = 0; i < k; i++) bclkPulse($urandom_range(4, 2), $urandom_range(5, 3));
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_div"}, 32'(divisor), 32'(mDiv));
    checkOutput({tag, "_samples"}, 32'(sampleCount), 32'(mSample));
    checkOutput({tag, "_bauds"}, 32'(baudCount), 32'(mBaud));
    checkOutput({tag, "_loads"}, 32'(loadCycles), 32'(mLoads));
  endtask

  initial begin
    logic [7:0] d;
    int v;
    $display("[TB] start");

    // Reset values.
    repeat (3) @(negedge clock);
    checkOutput("rst_rdata", 32'(regRdata), 32'h0);
    checkOutput("rst_genrstn", 32'(genRstn), 32'h0);
    checkOutput("rst_div", 32'(divisor), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ticks", 32'({sampleTick, baudTick}), 32'h0);
    resetN = 1'b1;

    // Enable with divisor 8: two reload cycles then running.
    writeDivisor(8);
    applyStimulus(2'd2, 8'h01);
    mEn = 1'b1; mDiv = 8; mLoads += RST_HOLD; mRun = 1'b1;
    checkOutput("en_div", 32'(divisor), 32'h8);
    checkOutput("en_load1_genrstn", 32'(genRstn), 32'h0);
    checkOutput("en_load1_busy", 32'(busy), 32'h1);
    @(negedge clock);
    checkOutput("en_load2_genrstn", 32'(genRstn), 32'h0);
    @(negedge clock);
    checkOutput("en_run_genrstn", 32'(genRstn), 32'h1);
    checkOutput("en_run_busy", 32'(busy), 32'h0);

    // Free-running ticks from a divide-by-8 bclk.
    for (int i = 0; i < 40; i++) bclkPulse(4, 4);
    checkCounters("run8");

    // Commit a new divisor: held pending until the next bclk rise.
    applyStimulus(2'd0, 8'h20);
    mShadow = 32'h20;
    applyStimulus(2'd2, 8'h03);
    mPend = 1'b1;
    checkOutput("commit_busy", 32'(busy), 32'h1);
    checkOutput("commit_div_held", 32'(divisor), 32'h8);
    bclkPulse(4, 4);
    checkCounters("apply20");
`ifdef UART_BAUD_CTRL_IRQ_EN
    checkOutput("irq_after_apply", 32'(irq), 32'h1);
`endif
    runPulses(20);
    checkCounters("run20");

    // Rejected commit of divisor 1: err flagged, then cleared by the read.
    writeDivisor(1);
    applyStimulus(2'd2, 8'h03);
    mErr = 1'b1;
    readStatusCheck("status_err");
`ifdef UART_BAUD_CTRL_IRQ_EN
    checkOutput("irq_cleared", 32'(irq), 32'h0);
`endif
    readStatusCheck("status_err_cleared");
    checkOutput("err_div_kept", 32'(divisor), 32'(mDiv));

    // Randomised commits, re-commits and rejected divisors.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(3, 0) != 0) begin
        writeDivisor($urandom_range(700, 2));
        applyStimulus(2'd2, 8'h03);
        mPend = 1'b1;
        if ($urandom_range(1, 0) == 1) writeDivisor($urandom_range(700, 2));
        checkOutput("rnd_pend_busy", 32'(busy), 32'h1);
        checkOutput("rnd_pend_div", 32'(divisor), 32'(mDiv));
      end else begin
        v = $urandom_range(1, 0);
        writeDivisor(v);
        applyStimulus(2'd2, 8'h03);
        mErr = 1'b1;
        readStatusCheck("rnd_status_err");
      end
      runPulses($urandom_range(20, 1));
      checkCounters("rnd");
    end
    checkOutput("no_tick_in_load", 32'(badTicks), 32'h0);

    // Disable together with a pending commit goes straight to OFF.
    writeDivisor(32'h30);
    applyStimulus(2'd2, 8'h03);
    mPend = 1'b1;
    applyStimulus(2'd2, 8'h02);
    mEn = 1'b0; mPend = 1'b0; mRun = 1'b0;
    checkOutput("dis_genrstn", 32'(genRstn), 32'h0);
    checkOutput("dis_busy", 32'(busy), 32'h0);
    readStatusCheck("dis_status");
    bclkPulse(4, 4);
    checkCounters("dis");

    // Reset asserted in the middle of a reload.
    applyStimulus(2'd2, 8'h01);
    checkOutput("midrst_in_load", 32'(busy && !genRstn), 32'h1);
    resetN = 1'b0;
    #1;
    checkOutput("midrst_rdata", 32'(regRdata), 32'h0);
    checkOutput("midrst_genrstn", 32'(genRstn), 32'h0);
    checkOutput("midrst_div", 32'(divisor), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_ticks", 32'({sampleTick, baudTick}), 32'h0);
`ifdef UART_BAUD_CTRL_IRQ_EN
    checkOutput("midrst_irq", 32'(irq), 32'h0);
`endif
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    mEn = 1'b0; mPend = 1'b0; mErr = 1'b0; mDone = 1'b0;
    readStatusCheck("post_rst_status");
    readReg(2'd0, d);
    checkOutput("post_rst_dll", 32'(d), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
